ads1675_frame_packer: RTL and testbench

- Downstream consumer of the ADS1675 serial-capture stage; accepts its 24-bit signed sample/valid pulse stream, same clock domain.
- Buffers samples in an internal FIFO and emits fixed-length frames on an AXI4-Stream master for the DAQ DMA/packet path.
- Each frame is one header word followed by FRAME_LEN sign-extended 32-bit sample words.
- Reports FIFO level and counts input overflow drops.

---
 rtl/ads1675_frame_packer.sv | 162 ++++++++++++++++
 tb/tb_ads1675_frame_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1675_frame_packer.sv
// ads1675_frame_packer
// Buffers 24-bit signed samples from the ADS1675 capture stage in a FIFO and
// emits fixed-length AXI4-Stream frames: one header word
// {SYNC, seq, FRAME_LEN} followed by FRAME_LEN sign-extended 32-bit samples.
// Input overruns are dropped and counted; status is clearable.
module ads1675_frame_packer #(
  parameter int         DW         = 24,
  parameter int         FRAME_LEN  = 64,
  parameter int         FIFO_DEPTH = 256,
  parameter logic [7:0] SYNC       = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DW-1:0]                 in_data,
  input  logic                          in_valid,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  input  logic                          clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FRAME_LEN_L = LW'(FRAME_LEN);
  localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
  localparam logic [15:0]   LAST_IDX    = 16'(FRAME_LEN - 1);
  localparam logic [15:0]   FRAME_LEN_W = 16'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    seq_q, seq_d;
  logic          overflow_q;
  logic [15:0]   drop_cnt_q;
  logic          hs, push, pop, drop, last_word;
  logic [DW-1:0] head;

  // Handshake and FIFO control; the write decision uses the level registered
  // at the start of the cycle, so a full FIFO rejects even if it pops now.
  assign hs        = m_tvalid && m_tready;
  assign push      = in_valid && en && (level_q < DEPTH_L);
  assign drop      = in_valid && en && (level_q == DEPTH_L);
  assign pop       = hs && (state_q == PAYLOAD);
  assign last_word = (state_q == PAYLOAD) && (cnt_q == LAST_IDX);
  assign level_d   = level_q + LW'(push) - LW'(pop);
  assign head      = mem[rd_ptr_q];

  // Sample storage.
  // NOTE: the data array carries no reset; validity is tracked by the
  // pointers and level, so only those need clearing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // FSM state register with payload counter and frame sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
  end

  // FSM next state: start a frame only once a whole frame is buffered, and
  // chain straight into the next header when another frame is ready.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    unique case (state_q)
      IDLE: begin
        if (level_d >= FRAME_LEN_L) state_d = HEADER;
      end
      HEADER: begin
        if (hs) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
        end
      end
      PAYLOAD: begin
        if (hs) begin
          if (last_word) begin
            seq_d   = seq_q + 8'd1;
            state_d = (level_d >= FRAME_LEN_L) ? HEADER : IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: decoded purely from registered state, so data and last stay
  // stable while the sink stalls.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    unique case (state_q)
      HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = {SYNC, seq_q, FRAME_LEN_W};
      end
      PAYLOAD: begin
        m_tvalid = 1'b1;
        m_tlast  = last_word;
        m_tdata  = {{(32-DW){head[DW-1]}}, head};
      end
      default: ;
    endcase
  end

  // Drop status: a drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_status)               drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (clr_status) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ads1675_frame_packer.sv
// Directed testbench for ads1675_frame_packer with FRAME_LEN=4, FIFO_DEPTH=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_ads1675_frame_packer;

  localparam int DW = 24;
  localparam int FL = 4;
  localparam int FD = 8;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          en         = 1'b0;
  logic [DW-1:0] in_data    = '0;
  logic          in_valid   = 1'b0;
  logic          m_tready   = 1'b0;
  logic          clr_status = 1'b0;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [3:0]    fifo_level;
  logic          overflow;
  logic [15:0]   drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ads1675_frame_packer #(
    .DW(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .SYNC(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .fifo_level(fifo_level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_status(clr_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (drive point).
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (sample point).
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    adv();
    in_valid = 1'b0;
  endtask

  // Expect one word on the stream, waiting at most max_wait extra cycles for
  // m_tvalid; with m_tready high the following edge completes the handshake.
  task automatic exp_word(input string tag, input logic [31:0] d, input logic l,
                          input int max_wait);
    int n = 0;
    mid();
    while (!m_tvalid && n < max_wait) begin
      adv();
      mid();
      n++;
    end
    check({tag, " tvalid"}, 32'(m_tvalid), 32'd1);
    check({tag, " tdata"},  m_tdata, d);
    check({tag, " tlast"},  32'(m_tlast), 32'(l));
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] smp [4];

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    check("rst tvalid", 32'(m_tvalid), 32'd0);
    check("rst tlast",  32'(m_tlast), 32'd0);
    check("rst tdata",  m_tdata, 32'd0);
    check("rst level",  32'(fifo_level), 32'd0);
    check("rst ovf",    32'(overflow), 32'd0);
    check("rst drops",  32'(drop_cnt), 32'd0);
    adv();
    adv();
    rst_n    = 1'b1;
    en       = 1'b1;
    m_tready = 1'b1;
    adv();

    // ---- basic frame: sign extension, tlast, one-cycle header latency ----
    push(24'h000001);
    push(24'hFFFFFF);
    push(24'h7FFFFF);
    push(24'h800000);
    exp_word("f0 hdr", 32'hA500_0004, 1'b0, 0);
    exp_word("f0 w0",  32'h0000_0001, 1'b0, 0);
    exp_word("f0 w1",  32'hFFFF_FFFF, 1'b0, 0);
    exp_word("f0 w2",  32'h007F_FFFF, 1'b0, 0);
    exp_word("f0 w3",  32'hFF80_0000, 1'b1, 0);
    mid();
    check("f0 idle tvalid", 32'(m_tvalid), 32'd0);
    check("f0 idle level",  32'(fifo_level), 32'd0);
    adv();

    push(24'h000010);
    push(24'h000020);
    push(24'h000030);
    push(24'h000040);
    exp_word("f1 hdr", 32'hA501_0004, 1'b0, 0);
    exp_word("f1 w0",  32'h0000_0010, 1'b0, 0);
    exp_word("f1 w1",  32'h0000_0020, 1'b0, 0);
    exp_word("f1 w2",  32'h0000_0030, 1'b0, 0);
    exp_word("f1 w3",  32'h0000_0040, 1'b1, 0);

    // ---- backpressure on the 2nd payload word ----
    push(24'h000005);
    push(24'h000006);
    push(24'h000007);
    push(24'h000008);
    exp_word("bp hdr", 32'hA502_0004, 1'b0, 0);
    exp_word("bp w0",  32'h0000_0005, 1'b0, 0);
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      check($sformatf("bp hold%0d tvalid", i), 32'(m_tvalid), 32'd1);
      check($sformatf("bp hold%0d tdata", i),  m_tdata, 32'h0000_0006);
      check($sformatf("bp hold%0d tlast", i),  32'(m_tlast), 32'd0);
      adv();
    end
    m_tready = 1'b1;
    exp_word("bp w1", 32'h0000_0006, 1'b0, 0);
    exp_word("bp w2", 32'h0000_0007, 1'b0, 0);
    exp_word("bp w3", 32'h0000_0008, 1'b1, 0);

    // ---- overflow: 10 pushes into an 8-deep FIFO with the sink stalled ----
    m_tready = 1'b0;
    for (int i = 1; i <= 10; i++) push(24'(i));
    mid();
    check("ovf level",  32'(fifo_level), 32'd8);
    check("ovf flag",   32'(overflow), 32'd1);
    check("ovf drops",  32'(drop_cnt), 32'd2);
    check("ovf tvalid", 32'(m_tvalid), 32'd1);
    check("ovf tdata",  m_tdata, 32'hA503_0004);
    adv();
    m_tready = 1'b1;
    exp_word("ovf f0 hdr", 32'hA503_0004, 1'b0, 0);
    for (int i = 1; i <= 4; i++)
      exp_word($sformatf("ovf f0 w%0d", i - 1), 32'(i), (i == 4), 0);
    exp_word("ovf f1 hdr", 32'hA504_0004, 1'b0, 0);
    for (int i = 5; i <= 8; i++)
      exp_word($sformatf("ovf f1 w%0d", i - 5), 32'(i), (i == 8), 0);
    mid();
    check("ovf drained tvalid", 32'(m_tvalid), 32'd0);
    adv();

    clr_status = 1'b1;
    adv();
    clr_status = 1'b0;
    mid();
    check("clr flag",  32'(overflow), 32'd0);
    check("clr drops", 32'(drop_cnt), 32'd0);
    adv();

    // ---- drop coincident with clear: the drop wins ----
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(24'(8'h11 + i));
    in_valid   = 1'b1;
    in_data    = 24'h000099;
    clr_status = 1'b1;
    adv();
    in_valid   = 1'b0;
    clr_status = 1'b0;
    mid();
    check("drop+clr flag",  32'(overflow), 32'd1);
    check("drop+clr drops", 32'(drop_cnt), 32'd1);
    check("drop+clr level", 32'(fifo_level), 32'd8);
    adv();
    m_tready = 1'b1;
    exp_word("dc f0 hdr", 32'hA505_0004, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      exp_word($sformatf("dc f0 w%0d", i), 32'(8'h11 + i), (i == 3), 0);
    exp_word("dc f1 hdr", 32'hA506_0004, 1'b0, 0);
    for (int i = 4; i < 8; i++)
      exp_word($sformatf("dc f1 w%0d", i - 4), 32'(8'h11 + i), (i == 7), 0);

    // ---- reset in the middle of a payload ----
    push(24'h000021);
    push(24'h000022);
    push(24'h000023);
    push(24'h000024);
    exp_word("mr hdr", 32'hA507_0004, 1'b0, 0);
    exp_word("mr w0",  32'h0000_0021, 1'b0, 0);
    exp_word("mr w1",  32'h0000_0022, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("mr async tvalid", 32'(m_tvalid), 32'd0);
    check("mr async level",  32'(fifo_level), 32'd0);
    check("mr async tdata",  m_tdata, 32'd0);
    adv();
    adv();
    rst_n = 1'b1;
    adv();
    mid();
    check("mr no resume tvalid", 32'(m_tvalid), 32'd0);
    adv();
    push(24'h000031);
    push(24'h000032);
    push(24'h000033);
    push(24'h000034);
    exp_word("mr new hdr", 32'hA500_0004, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      exp_word($sformatf("mr new w%0d", i), 32'(8'h31 + i), (i == 3), 0);

    // ---- sequence wrap over 257 frames from a fresh reset ----
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    adv();
    for (int f = 0; f < 257; f++) begin
      for (int j = 0; j < 4; j++) begin
        smp[j]     = 24'(f * 4 + j);
        smp[j][23] = f[0];
        push(smp[j]);
      end
      exp_word($sformatf("wrap f%0d hdr", f + 1), {8'hA5, 8'(f), 16'h0004}, 1'b0, 0);
      for (int j = 0; j < 4; j++)
        exp_word($sformatf("wrap f%0d w%0d", f + 1, j),
                 {{8{smp[j][23]}}, smp[j]}, (j == 3), 0);
    end

    // ---- enable gating ----
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(8'h50 + i);
      adv();
      in_valid = 1'b0;
      mid();
      check($sformatf("en0 empty%0d level", i),  32'(fifo_level), 32'd0);
      check($sformatf("en0 empty%0d drops", i),  32'(drop_cnt), 32'd0);
      check($sformatf("en0 empty%0d tvalid", i), 32'(m_tvalid), 32'd0);
      adv();
    end
    en       = 1'b1;
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(24'(8'h41 + i));
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(8'h60 + i);
      adv();
      in_valid = 1'b0;
      mid();
      check($sformatf("en0 full%0d level", i), 32'(fifo_level), 32'd8);
      check($sformatf("en0 full%0d drops", i), 32'(drop_cnt), 32'd0);
      check($sformatf("en0 full%0d ovf", i),   32'(overflow), 32'd0);
      adv();
    end
    m_tready = 1'b1;
    exp_word("en0 f0 hdr", 32'hA501_0004, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      exp_word($sformatf("en0 f0 w%0d", i), 32'(8'h41 + i), (i == 3), 0);
    exp_word("en0 f1 hdr", 32'hA502_0004, 1'b0, 0);
    for (int i = 4; i < 8; i++)
      exp_word($sformatf("en0 f1 w%0d", i - 4), 32'(8'h41 + i), (i == 7), 0);
    mid();
    check("en0 drained level",  32'(fifo_level), 32'd0);
    check("en0 drained tvalid", 32'(m_tvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
